// File: rtl/process_scheduler_pkg.sv
// Shared types for the round-robin process scheduler: FSM states, slot status, priority.
package sched_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE,
    S_SELECT,
    S_DISPATCH,
    S_RUN
  } state_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_READY,
    ST_DONE
  } slot_st_t;

  typedef logic [1:0] prio_t;
endpackage

// File: rtl/process_scheduler_if.sv
// OS-side bus: slot loading plus the dispatch valid/ack handshake.
// load_prio exists only when SCHED_PRIORITY_EN is defined.
interface process_scheduler_if #(
  parameter int ID_W = 2,
  parameter int PC_W = 32
);
  import sched_pkg::*;

  logic            load_en;
  logic [ID_W-1:0] load_id;
  logic [PC_W-1:0] load_pc;
`ifdef SCHED_PRIORITY_EN
  prio_t           load_prio;
`endif
  logic            dispatch_ack;
  logic            dispatch_valid;
  logic [PC_W-1:0] dispatch_pc;
  logic [ID_W-1:0] dispatch_id;

  modport master (
    output load_en, load_id, load_pc,
`ifdef SCHED_PRIORITY_EN
    output load_prio,
`endif
    output dispatch_ack,
    input  dispatch_valid, dispatch_pc, dispatch_id
  );

  modport slave (
    input  load_en, load_id, load_pc,
`ifdef SCHED_PRIORITY_EN
    input  load_prio,
`endif
    input  dispatch_ack,
    output dispatch_valid, dispatch_pc, dispatch_id
  );
endinterface

// File: rtl/process_scheduler_rr_picker.sv
// Combinational round-robin picker: first READY slot from start, wrapping.
// With SCHED_PRIORITY_EN the highest priority wins and round-robin order breaks ties.
module rr_picker
  import sched_pkg::*;
#(
  parameter int NUM_PROCS = 4,
  parameter int ID_W      = 2
) (
  input  logic [NUM_PROCS-1:0] ready,
  input  logic [ID_W-1:0]      start,
`ifdef SCHED_PRIORITY_EN
  input  prio_t [NUM_PROCS-1:0] prio,
`endif
  output logic                 found,
  output logic [ID_W-1:0]      idx
);
  logic [ID_W-1:0] cand;
`ifdef SCHED_PRIORITY_EN
  prio_t best;
`endif

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
`ifdef SCHED_PRIORITY_EN
    best  = '0;
`endif
    for (int k = 0; k < NUM_PROCS; k++) begin
      // NUM_PROCS is a power of two, so the add wraps on its own
      cand = start + ID_W'(k);
`ifdef SCHED_PRIORITY_EN
      if (ready[cand] && (!found || prio[cand] > best)) begin
        found = 1'b1;
        idx   = cand;
        best  = prio[cand];
      end
`else
      if (ready[cand] && !found) begin
        found = 1'b1;
        idx   = cand;
      end
`endif
    end
  end
endmodule

// File: rtl/process_scheduler.sv
// Round-robin context scheduler: saves the interrupted PC, picks the next READY slot,
// hands it to the OS via valid/ack. Optional SCHED_PRIORITY_EN enables per-slot priority.
module process_scheduler
  import sched_pkg::*;
#(
  parameter int NUM_PROCS = 4,
  parameter int ID_W      = 2,
  parameter int PC_W      = 32
) (
  input  logic                clock,
  input  logic                reset_geral,
  input  logic                preempt_req,
  input  logic                halt_req,
  input  logic [PC_W-1:0]     saved_pc,
  process_scheduler_if.slave  os,
  output logic [ID_W-1:0]     cur_id,
  output logic                running,
  output logic                all_done
);
  state_t          state, next_state;
  logic [PC_W-1:0] slot_pc [NUM_PROCS];
  slot_st_t        slot_st [NUM_PROCS];
`ifdef SCHED_PRIORITY_EN
  prio_t [NUM_PROCS-1:0] slot_prio;
`endif
  logic [NUM_PROCS-1:0] ready_mask;
  logic [PC_W-1:0] save_pc;
  logic            save_halt;
  logic            pick_found;
  logic [ID_W-1:0] pick_id;

  always_comb begin
    ready_mask = '0;
    for (int i = 0; i < NUM_PROCS; i++) ready_mask[i] = (slot_st[i] == ST_READY);
  end

  rr_picker #(.NUM_PROCS(NUM_PROCS), .ID_W(ID_W)) u_picker (
    .ready (ready_mask),
    .start (cur_id + 1'b1),
`ifdef SCHED_PRIORITY_EN
    .prio  (slot_prio),
`endif
    .found (pick_found),
    .idx   (pick_id)
  );

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:     if (|ready_mask) next_state = S_SELECT;
      S_RUN:      if (halt_req || preempt_req) next_state = S_SAVE;
      S_SAVE:     next_state = S_SELECT;
      S_SELECT:   next_state = pick_found ? S_DISPATCH : S_IDLE;
      S_DISPATCH: if (os.dispatch_ack) next_state = S_RUN;
      default:    next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset_geral) begin
      state          <= S_IDLE;
      cur_id         <= ID_W'(NUM_PROCS - 1);
      os.dispatch_pc <= '0;
      os.dispatch_id <= '0;
      save_pc        <= '0;
      save_halt      <= 1'b0;
      for (int i = 0; i < NUM_PROCS; i++) begin
        slot_pc[i] <= '0;
        slot_st[i] <= ST_EMPTY;
      end
`ifdef SCHED_PRIORITY_EN
      slot_prio <= '0;
`endif
    end else begin
      state <= next_state;
      // Captured in RUN, committed to the table during SAVE; halt beats preempt
      if (state == S_RUN && (halt_req || preempt_req)) begin
        save_halt <= halt_req;
        save_pc   <= saved_pc;
      end
      if (state == S_SELECT && pick_found) begin
        os.dispatch_id <= pick_id;
        os.dispatch_pc <= slot_pc[pick_id];
      end
      if (state == S_DISPATCH && os.dispatch_ack) cur_id <= os.dispatch_id;
      for (int i = 0; i < NUM_PROCS; i++) begin
        if (os.load_en && os.load_id == ID_W'(i)) begin
          slot_pc[i] <= os.load_pc;
          slot_st[i] <= ST_READY;
`ifdef SCHED_PRIORITY_EN
          slot_prio[i] <= os.load_prio;
`endif
        end else if (state == S_SAVE && cur_id == ID_W'(i)) begin
          if (save_halt) slot_st[i] <= ST_DONE;
          else           slot_pc[i] <= save_pc;
        end
      end
    end
  end

  assign os.dispatch_valid = (state == S_DISPATCH);
  assign running           = (state == S_RUN);
  assign all_done          = (state != S_RUN) && !(|ready_mask);
endmodule

// File: tb/tb_process_scheduler.sv
// Directed self-checking bench for process_scheduler (round-robin, optional priority).
module tb_process_scheduler;
  localparam int ID_W = 2;
  localparam int PC_W = 32;

  logic            clock = 1'b0;
  logic            reset_geral;
  logic            preempt_req, halt_req;
  logic [PC_W-1:0] saved_pc;
  logic [ID_W-1:0] cur_id;
  logic            running, all_done;
  int              errors = 0;
  int              checks = 0;

  process_scheduler_if #(.ID_W(ID_W), .PC_W(PC_W)) os_if ();

  process_scheduler #(.NUM_PROCS(4), .ID_W(ID_W), .PC_W(PC_W)) dut (
    .clock       (clock),
    .reset_geral (reset_geral),
    .preempt_req (preempt_req),
    .halt_req    (halt_req),
    .saved_pc    (saved_pc),
    .os          (os_if),
    .cur_id      (cur_id),
    .running     (running),
    .all_done    (all_done)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic load_slot(input logic [ID_W-1:0] id, input logic [PC_W-1:0] pc,
                           input logic [1:0] prio = 2'd0);
    os_if.load_en = 1'b1;
    os_if.load_id = id;
    os_if.load_pc = pc;
`ifdef SCHED_PRIORITY_EN
    os_if.load_prio = prio;
`endif
    tick();
    os_if.load_en = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (os_if.dispatch_valid === 1'b1) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic ack();
    os_if.dispatch_ack = 1'b1;
    tick();
    os_if.dispatch_ack = 1'b0;
  endtask

  // Pulse preempt/halt for one cycle, then step through SAVE and SELECT
  task automatic event_then_dispatch(input logic pre, input logic hlt, input logic [PC_W-1:0] pc);
    preempt_req = pre;
    halt_req    = hlt;
    saved_pc    = pc;
    tick();
    preempt_req = 1'b0;
    halt_req    = 1'b0;
    tick(2);
  endtask

  task automatic check_dispatch(input string name, input logic [ID_W-1:0] id, input logic [PC_W-1:0] pc);
    checks++;
    if (os_if.dispatch_valid !== 1'b1 || os_if.dispatch_id !== id || os_if.dispatch_pc !== pc) begin
      errors++;
      $display("FAIL %s: valid=%b id=%0d pc=%0h, expected valid=1 id=%0d pc=%0h",
               name, os_if.dispatch_valid, os_if.dispatch_id, os_if.dispatch_pc, id, pc);
    end
  endtask

  task automatic do_reset();
    reset_geral = 1'b1;
    tick(2);
    reset_geral = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({os_if.dispatch_valid, os_if.dispatch_pc, os_if.dispatch_id, running, all_done, cur_id}
        !== {1'b0, 32'd0, 2'd0, 1'b0, 1'b1, 2'd3}) begin
      errors++;
      $display("FAIL reset: valid=%b pc=%0h id=%0d run=%b done=%b cur=%0d, expected 0 0 0 0 1 3",
               os_if.dispatch_valid, os_if.dispatch_pc, os_if.dispatch_id, running, all_done, cur_id);
    end
  endtask

  task automatic test_first_dispatch();
    bit ok;
    load_slot(2'd0, 32'd10);
    load_slot(2'd1, 32'd20);
    load_slot(2'd2, 32'd30);
    wait_valid(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL first_wait: dispatch_valid never rose, expected 1"); end
    check_dispatch("first_dispatch", 2'd0, 32'd10);
    ack();
    checks++;
    if (running !== 1'b1 || cur_id !== 2'd0 || os_if.dispatch_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_ack: run=%b cur=%0d valid=%b, expected 1 0 0", running, cur_id, os_if.dispatch_valid);
    end
  endtask

  task automatic test_preempt_latency();
    preempt_req = 1'b1;
    saved_pc    = 32'd14;
    tick();
    preempt_req = 1'b0;
    checks++;
    if (running !== 1'b0 || os_if.dispatch_valid !== 1'b0) begin
      errors++;
      $display("FAIL save_cycle: run=%b valid=%b, expected 0 0", running, os_if.dispatch_valid);
    end
    tick();
    checks++;
    if (os_if.dispatch_valid !== 1'b0) begin
      errors++;
      $display("FAIL select_cycle: valid=%b, expected 0", os_if.dispatch_valid);
    end
    tick();
    check_dispatch("preempt_next", 2'd1, 32'd20);
    ack();
  endtask

  task automatic test_wrap();
    event_then_dispatch(1'b1, 1'b0, 32'd24);
    check_dispatch("rr_to_2", 2'd2, 32'd30);
    ack();
    event_then_dispatch(1'b1, 1'b0, 32'd33);
    check_dispatch("wrap_to_0_saved_pc", 2'd0, 32'd14);
    ack();
    event_then_dispatch(1'b0, 1'b1, 32'd0);
    check_dispatch("halt0_to_1", 2'd1, 32'd24);
    ack();
  endtask

  task automatic test_halt();
    event_then_dispatch(1'b1, 1'b1, 32'd99);
    check_dispatch("halt_wins_to_2", 2'd2, 32'd33);
    ack();
    event_then_dispatch(1'b1, 1'b0, 32'd37);
    check_dispatch("self_redispatch", 2'd2, 32'd37);
    ack();
    event_then_dispatch(1'b0, 1'b1, 32'd0);
    checks++;
    if (os_if.dispatch_valid !== 1'b0 || running !== 1'b0 || all_done !== 1'b1) begin
      errors++;
      $display("FAIL all_halted: valid=%b run=%b done=%b, expected 0 0 1",
               os_if.dispatch_valid, running, all_done);
    end
    tick(3);
    checks++;
    if (os_if.dispatch_valid !== 1'b0 || all_done !== 1'b1) begin
      errors++;
      $display("FAIL idle_stays: valid=%b done=%b, expected 0 1", os_if.dispatch_valid, all_done);
    end
  endtask

  task automatic test_load_save_collision();
    bit ok;
    do_reset();
    load_slot(2'd0, 32'h100);
    wait_valid(ok);
    check_dispatch("coll_first", 2'd0, 32'h100);
    ack();
    preempt_req = 1'b1;
    saved_pc    = 32'h104;
    tick();
    preempt_req = 1'b0;
    load_slot(2'd0, 32'h200);
    tick();
    check_dispatch("load_beats_save", 2'd0, 32'h200);
    ack();
  endtask

  task automatic test_hold_and_reset();
    bit ok;
    do_reset();
    load_slot(2'd3, 32'h40);
    wait_valid(ok);
    check_dispatch("hold_first", 2'd3, 32'h40);
    for (int i = 0; i < 5; i++) begin
      preempt_req = 1'b1;
      halt_req    = (i == 2);
      saved_pc    = 32'hDEAD;
      if (i == 3) load_slot(2'd3, 32'h50);
      else tick();
      check_dispatch($sformatf("hold_cycle%0d", i), 2'd3, 32'h40);
    end
    preempt_req = 1'b0;
    halt_req    = 1'b0;
    reset_geral = 1'b1;
    os_if.dispatch_ack = 1'b1;
    tick();
    checks++;
    if ({os_if.dispatch_valid, os_if.dispatch_pc, os_if.dispatch_id, running, all_done, cur_id}
        !== {1'b0, 32'd0, 2'd0, 1'b0, 1'b1, 2'd3}) begin
      errors++;
      $display("FAIL reset_in_dispatch: valid=%b pc=%0h id=%0d run=%b done=%b cur=%0d, expected 0 0 0 0 1 3",
               os_if.dispatch_valid, os_if.dispatch_pc, os_if.dispatch_id, running, all_done, cur_id);
    end
    reset_geral = 1'b0;
    os_if.dispatch_ack = 1'b0;
  endtask

`ifdef SCHED_PRIORITY_EN
  task automatic test_priority();
    bit ok;
    do_reset();
    load_slot(2'd0, 32'h10, 2'd1);
    load_slot(2'd1, 32'h20, 2'd3);
    load_slot(2'd2, 32'h30, 2'd3);
    wait_valid(ok);
    check_dispatch("prio_first", 2'd1, 32'h20);
    ack();
    event_then_dispatch(1'b1, 1'b0, 32'h24);
    check_dispatch("prio_tie_rr", 2'd2, 32'h30);
    ack();
  endtask
`endif

  initial begin
    reset_geral        = 1'b1;
    preempt_req        = 1'b0;
    halt_req           = 1'b0;
    saved_pc           = '0;
    os_if.load_en      = 1'b0;
    os_if.load_id      = '0;
    os_if.load_pc      = '0;
`ifdef SCHED_PRIORITY_EN
    os_if.load_prio    = '0;
`endif
    os_if.dispatch_ack = 1'b0;
    test_reset();
    test_first_dispatch();
    test_preempt_latency();
    test_wrap();
    test_halt();
    test_load_save_collision();
    test_hold_and_reset();
`ifdef SCHED_PRIORITY_EN
    test_priority();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/process_scheduler.md
Name: process_scheduler

Overview:
Round-robin context scheduler that sits beside the program counter. It owns a table of user-program slots, each holding a saved PC and a status. On a preemption or halt event from the PC, it stores the interrupted PC, picks the next ready program, and hands the OS a dispatch PC/ID through a valid/ack handshake. The ID drives jump_prog.

Parameters:
NUM_PROCS, 4, number of program slots (power of 2, >=2)
ID_W, 2, slot index width, equal to log2(NUM_PROCS)
PC_W, 32, PC width

Ports:
clock  in  1  system clock, all logic on posedge
reset_geral  in  1  synchronous active-high reset
preempt_req  in  1  one-cycle pulse from PC: quantum expired (flag_faz_preempcao)
halt_req  in  1  one-cycle pulse: current program executed halt/finished
saved_pc  in  PC_W  PC of interrupted program (salva_PC), valid with preempt_req/halt_req
load_en  in  1  OS writes a slot
load_id  in  ID_W  slot to write
load_pc  in  PC_W  entry PC for slot
dispatch_ack  in  1  OS consumed dispatch
dispatch_valid  out  1  dispatch_pc/dispatch_id valid
dispatch_pc  out  PC_W  PC to resume
dispatch_id  out  ID_W  slot being dispatched
cur_id  out  ID_W  slot currently running
running  out  1  a user program owns the CPU
all_done  out  1  no slot READY and none running

Behaviour:
- Slot status per slot: EMPTY, READY, DONE. Reset: all slots EMPTY, all saved PCs 0.
- FSM states: IDLE, SAVE, SELECT, DISPATCH, RUN. Reset state: IDLE.
- Output reset values: dispatch_valid=0, dispatch_pc=0, dispatch_id=0, running=0, all_done=1. cur_id resets to NUM_PROCS-1, so the first search starts at slot 0.
- load_en, any state: slot[load_id] gets PC=load_pc and status READY on the next edge.
- IDLE: all_done=1 when no slot is READY. If any slot is READY, go to SELECT.
- RUN: running=1.
  - halt_req: go to SAVE and mark slot[cur_id] DONE.
  - preempt_req: go to SAVE and write saved_pc to slot[cur_id] (stays READY).
  - Both asserted together: halt wins, PC not stored.
- preempt_req/halt_req outside RUN are ignored (the OS runs in slot-less context).
- SAVE: one cycle for the table write, then SELECT.
- SELECT: one cycle. Search slots cur_id+1, cur_id+2, ... mod NUM_PROCS, wrapping, and including cur_id last. Take the first READY slot.
  - Found: latch dispatch_id/dispatch_pc and go to DISPATCH.
  - None: go to IDLE with all_done=1.
- Latency: preempt_req to dispatch_valid is exactly 2 clocks (SAVE, SELECT).
- DISPATCH: dispatch_valid=1 with stable dispatch_pc/dispatch_id until dispatch_ack. On the ack edge: cur_id=dispatch_id, dispatch_valid=0, go to RUN.
- load_en to the same slot in the same cycle as a SAVE-cycle write: load_en wins (slot READY, load_pc).
- load_en targeting the slot latched for dispatch in DISPATCH: the table updates, but the latched dispatch_pc does not.
- Only one program runs at a time, and the selected slot is always READY at SELECT time.
- reset_geral mid-operation, any state: full reset next edge and dispatch dropped. reset_geral has priority over every input.

Optional Feature:
SCHED_PRIORITY_EN.
- Defined: adds input load_prio [1:0], stored per slot with load_en. SELECT picks the highest-priority READY slot; ties are broken by the round-robin order above.
- Undefined: no load_prio port and pure round-robin.

Decomposition:
- Package sched_pkg:
  - FSM state enum
  - slot status enum (EMPTY/READY/DONE)
  - prio type
- Natural sub-module: rr_picker, combinational. Inputs are the ready mask, start index and (optional) priorities. Outputs are found and index.

Test Plan:
1. Reset, load slots 0/1/2 with PCs 10/20/30 → SELECT picks 0. dispatch_valid=1, pc=10, id=0. After ack: running=1, cur_id=0.
2. In RUN id=0, preempt_req with saved_pc=14 → 2 clocks later dispatch id=1, pc=20. slot0 PC reads back 14 on a later wrap.
3. Ids 0..2 loaded, cur_id=2, preempt saved_pc=33 → wraps to id=0. With only slot 2 READY → redispatches id=2, pc=33.
4. halt_req and preempt_req together in RUN id=1 → slot1 DONE, never dispatched again. Halt all three → IDLE, all_done=1.
5. dispatch_valid held 5 cycles without ack → dispatch_pc/id stable, preempt_req ignored. reset_geral during DISPATCH → next edge all outputs at reset values.
6. With SCHED_PRIORITY_EN: prio slot0=1, slot1=3, slot2=3, cur_id=1, preempt → dispatch id=2.
